// File: rtl/freq_calc.sv
// Frequency calculator: freq = F_CLK*M/N (truncated) after a gate_out falling edge,
// using a serial shift-add multiplier followed by a serial restoring divider.
module freq_calc #(
  parameter int F_CLK  = 50_000_000,
  parameter int MW     = 31,
  parameter int NW     = 27,
  parameter int QW     = 32,
  parameter int SETTLE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gate_out,
  input  logic [MW-1:0] M,
  input  logic [NW-1:0] N,
  output logic [QW-1:0] freq,
  output logic          freq_valid,
  output logic          busy,
  output logic          err_zero,
  output logic          ovf
);

  localparam int PW   = MW + 26;
  localparam int CMPW = NW + QW;
  localparam int CW   = 8;

  typedef enum logic [2:0] {IDLE, WAIT, MUL, CHK, DIV, DONE} state_t;

  state_t          state_q;
  logic [2:0]      sync_q;
  logic [CW-1:0]   cnt_q;
  logic [MW-1:0]   mr_q;
  logic [NW-1:0]   nr_q;
  logic [PW-1:0]   p_q;
  logic [PW-1:0]   mcand_q;
  logic [NW:0]     rem_q;
  logic [QW-1:0]   quo_q;
  logic [QW-1:0]   freq_q;
  logic            valid_q;
  logic            busy_q;
  logic            err_q;
  logic            ovf_q;

  logic            fall;
  logic [PW-1:0]   p_d;
  logic [NW+1:0]   trial;
  logic            geq;
  logic [NW:0]     rem_d;
  logic [QW-1:0]   quo_d;
  logic            ovfHit;

  // The dividend's low bits live in quo_q and shift into the remainder MSB first,
  // while quotient bits shift in from the bottom.
  always_comb begin
    fall   = sync_q[2] & ~sync_q[1];
    p_d    = mr_q[0] ? (p_q + mcand_q) : p_q;
    trial  = {rem_q, quo_q[QW-1]};
    geq    = (trial >= {2'b00, nr_q});
    rem_d  = geq ? (NW+1)'(trial - {2'b00, nr_q}) : (NW+1)'(trial);
    quo_d  = {quo_q[QW-2:0], geq};
    ovfHit = ({{(CMPW-PW){1'b0}}, p_q} >= {nr_q, {QW{1'b0}}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      mr_q    <= '0;
      nr_q    <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], gate_out};
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= WAIT;
            cnt_q   <= CW'(SETTLE - 1);
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            mr_q    <= M;
            nr_q    <= N;
            p_q     <= '0;
            mcand_q <= PW'(F_CLK);
            cnt_q   <= CW'(MW - 1);
            if (N == '0) begin
              state_q <= DONE;
              freq_q  <= '0;
              err_q   <= 1'b1;
              ovf_q   <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= MUL;
              busy_q  <= 1'b1;
            end
          end
        end
        MUL: begin
          p_q     <= p_d;
          mcand_q <= mcand_q << 1;
          mr_q    <= mr_q >> 1;
          if (cnt_q == '0) state_q <= CHK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        // Quotient fits in QW bits only if P < N*2^QW; otherwise saturate early.
        CHK: begin
          if (ovfHit) begin
            state_q <= DONE;
            freq_q  <= '1;
            ovf_q   <= 1'b1;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DIV;
            rem_q   <= (NW+1)'(p_q[PW-1:QW]);
            quo_q   <= p_q[QW-1:0];
            cnt_q   <= CW'(QW - 1);
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
            freq_q  <= quo_d;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign busy       = busy_q;
  assign err_zero   = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_freq_calc.sv
// Self-checking bench for freq_calc: a cycle-level reference model of result values,
// latency and busy window, with directed cases plus randomized measurements.
module tb_freq_calc;

   logic        clock;
   logic        rst;
   logic        gateOut;
   logic [30:0] mIn;
   logic [26:0] nIn;
   logic [31:0] freq;
   logic        freqValid;
   logic        busy;
   logic        errZero;
   logic        ovf;

   int asserts  = 0;
   int failures = 0;
   int cycleCnt = 0;

   bit          pend = 0;
   int          dueCycle = 0;
   int          pendLat = 0;
   logic [31:0] pendFreq = '0;
   logic        pendErr = 0;
   logic        pendOvf = 0;

   logic [31:0] holdFreq = '0;
   logic        holdErr = 0;
   logic        holdOvf = 0;

   freq_calc dut (
      .clk(clock), .rst(rst), .gate_out(gateOut), .M(mIn), .N(nIn),
      .freq(freq), .freq_valid(freqValid), .busy(busy),
      .err_zero(errZero), .ovf(ovf)
   );

   // 100 MHz bench clock
   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycleCnt);
      end
   endtask

   // Result of one measurement from plain arithmetic: F_CLK*M/N, with latency.
   function automatic void model(input logic [30:0] m, input logic [26:0] n,
                                 output logic [31:0] f, output logic e,
                                 output logic o, output int lat);
      longint unsigned p;
      longint unsigned lim;
      p   = 64'd50_000_000 * longint'(m);
      lim = longint'(n) << 32;
      if (n == 0) begin
         f = 0; e = 1; o = 0; lat = 5;
      end else if (p >= lim) begin
         f = 32'hFFFF_FFFF; e = 0; o = 1; lat = 4 + 31 + 2;
      end else begin
         f = 32'(p / longint'(n)); e = 0; o = 0; lat = 4 + 31 + 32 + 2;
      end
   endfunction

   // Every negative edge the outputs are compared with the model's held result.
   always @(negedge clock) begin
      logic expValid;
      logic expBusy;
      if (!rst) begin
         holdFreq = '0; holdErr = 0; holdOvf = 0;
         check("resetFreq", freq, 0);
         check("resetValid", freqValid, 0);
         check("resetBusy", busy, 0);
      end else begin
         expValid = pend && (cycleCnt == dueCycle);
         expBusy  = pend && (cycleCnt >= dueCycle - pendLat + 5) && (cycleCnt < dueCycle);
         if (expValid) begin
            holdFreq = pendFreq; holdErr = pendErr; holdOvf = pendOvf;
         end
         check("freqValid", freqValid, expValid);
         check("busy", busy, expBusy);
         check("freq", freq, holdFreq);
         check("errZero", errZero, holdErr);
         check("ovf", ovf, holdOvf);
      end
   end

   // Drop gate_out with M/N applied; optionally fire a second fall glitchAt cycles later.
   task automatic applyStimulus(input logic [30:0] m, input logic [26:0] n, input int glitchAt);
      int c;
      int guard;
      @(posedge clock); #1;
      mIn = m; nIn = n; gateOut = 0;
      c = cycleCnt;
      model(m, n, pendFreq, pendErr, pendOvf, pendLat);
      dueCycle = c + 2 + pendLat;
      pend = 1;
      if (glitchAt > 0) begin
         repeat (glitchAt) @(posedge clock);
         #1 gateOut = 1; mIn = 31'($urandom); nIn = 27'($urandom);
         repeat (3) @(posedge clock);
         #1 gateOut = 0;
      end
      guard = 0;
      while (cycleCnt < dueCycle + 2 && guard < 200) begin
         @(posedge clock);
         guard++;
      end
      #1;
      gateOut = 1;
      pend = 0;
      repeat (3) @(posedge clock);
   endtask

   task automatic checkOutput(input logic [31:0] f, input logic e, input logic o);
      #1;
      check("litFreq", freq, f);
      check("litErr", errZero, e);
      check("litOvf", ovf, o);
   endtask

   initial begin
      logic [30:0] m;
      logic [26:0] n;
      longint unsigned p;
      rst = 0; gateOut = 1; mIn = 0; nIn = 0;
      #1;
      check("resetFreqAsync", freq, 0);
      check("resetFlags", {errZero, ovf, freqValid, busy}, 0);
      repeat (3) @(posedge clock);
      #1 rst = 1;
      repeat (3) @(posedge clock);

      applyStimulus(31'd1_000_000, 27'd50_000_000, 0);
      checkOutput(32'd1_000_000, 0, 0);
      applyStimulus(31'd7, 27'd3, 0);
      checkOutput(32'd116_666_666, 0, 0);
      applyStimulus(31'd5, 27'd0, 0);
      checkOutput(32'd0, 1, 0);
      applyStimulus(31'h7FFF_FFFF, 27'd1, 0);
      checkOutput(32'hFFFF_FFFF, 0, 1);
      applyStimulus(31'd0, 27'd12345, 0);
      checkOutput(32'd0, 0, 0);
      applyStimulus(31'd1000, 27'd50_000, 44);
      checkOutput(32'd1_000_000, 0, 0);

      // Reset while the multiplier is running aborts the measurement
      @(posedge clock); #1;
      mIn = 31'd5; nIn = 27'd50_000_000; gateOut = 0;
      model(mIn, nIn, pendFreq, pendErr, pendOvf, pendLat);
      dueCycle = cycleCnt + 2 + pendLat;
      pendLat = pendLat;
      pend = 1;
      repeat (20) @(posedge clock);
      #1 pend = 0; rst = 0;
      #1;
      check("midResetFreq", freq, 0);
      check("midResetOut", {freqValid, busy, errZero, ovf}, 0);
      repeat (2) @(posedge clock);
      #1 rst = 1; gateOut = 1;
      repeat (4) @(posedge clock);
      applyStimulus(31'd3, 27'd50_000_000, 0);
      checkOutput(32'd3, 0, 0);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               m = 31'($urandom_range(0, 1 << 20));
               n = 27'($urandom_range(1 << 20, (1 << 27) - 1));
            end
            1: begin
               m = 31'($urandom);
               n = 27'($urandom);
            end
            2: begin
               m = 31'($urandom);
               n = 0;
            end
            default: begin
               m = 31'($urandom);
               p = 64'd50_000_000 * longint'(m);
               n = 27'((p >> 32) + longint'($urandom_range(0, 1)));
               if (n == 0) n = 1;
            end
         endcase
         applyStimulus(m, n, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
